// File: rtl/ofs_rst_seq.sv
// ofs_rst_seq: waits for a stable PLL lock, then releases NUM_CH reset domains in order.
// Optional lock-wait watchdog is built when RST_SEQ_WDOG_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HOLD    | all sequence resets asserted, waiting for lock_s
// ST_STABLE  | counting consecutive locked cycles
// ST_RELEASE | channels 0..idx released, counting the inter-channel gap
// ST_RUN     | all sequence resets released, seq_done high
module ofs_rst_seq #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int STABLE_CYC = 1024,
  parameter int GAP_CYC    = 64,
  parameter int WDOG_CYC   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_hold_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              seq_done,
  output logic [7:0]        lock_lost_cnt,
  output logic              wdog_timeout
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STABLE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              lock_meta, lock_s;
  logic              lock_loss, hold_entry;
  logic [NUM_CH-1:0] seq_rst;

  // pll_locked comes from another clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Outside HOLD lock_s was high last cycle, so a low level here is a falling edge.
  always_comb begin
    lock_loss  = (state_q != ST_HOLD) && !lock_s;
    hold_entry = lock_loss || sw_rst_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_HOLD: begin
        cnt_d = '0;
        idx_d = '0;
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (cnt_q == STABLE_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = ST_RUN;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    if (hold_entry) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  always_comb begin
    seq_rst = {NUM_CH{1'b1}};
    case (state_q)
      ST_RELEASE: begin
        for (int i = 0; i < NUM_CH; i++) seq_rst[i] = (IDX_W'(i) > idx_q);
      end
      ST_RUN:  seq_rst = '0;
      default: seq_rst = {NUM_CH{1'b1}};
    endcase
  end

  // Re-assertion bypasses the state register so every channel drops back in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_out       <= {NUM_CH{1'b1}};
      seq_done      <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      rst_out  <= (hold_entry ? {NUM_CH{1'b1}} : seq_rst) | ch_hold_req;
      seq_done <= (state_q == ST_RUN) && !hold_entry;
      if (lock_loss && (lock_lost_cnt != 8'hFF))
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

`ifdef RST_SEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_flag;
  logic              wdog_run;

  assign wdog_run = (state_q == ST_HOLD) && !lock_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_flag <= 1'b0;
    end else begin
      if ((state_q != ST_HOLD) || sw_rst_req)
        wdog_cnt <= '0;
      else if (wdog_run && (wdog_cnt != WDOG_W'(WDOG_CYC)))
        wdog_cnt <= wdog_cnt + WDOG_W'(1);

      if (sw_rst_req)
        wdog_flag <= 1'b0;
      else if (wdog_run && (wdog_cnt == WDOG_W'(WDOG_CYC - 1)))
        wdog_flag <= 1'b1;
    end
  end

  assign wdog_timeout = wdog_flag;
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ofs_rst_seq.sv
// Scoreboard bench for ofs_rst_seq: stimulus queues expected output changes,
// a monitor pops one entry per observed change and checks value and cycle.
module tb_ofs_rst_seq;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 16;
  localparam int STABLE_CYC = 16;
  localparam int GAP_CYC    = 4;
  localparam int WDOG_CYC   = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pll_locked = 1'b0;
  logic              sw_rst_req = 1'b0;
  logic [NUM_CH-1:0] ch_hold_req = '0;
  logic [NUM_CH-1:0] rst_out;
  logic              seq_done;
  logic [7:0]        lock_lost_cnt;
  logic              wdog_timeout;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic       d;
    logic [7:0] l;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  logic [3:0] er = 4'hF;
  logic       ed = 1'b0;
  logic [7:0] el = 8'd0;
  logic       ew = 1'b0;

  ofs_rst_seq #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .STABLE_CYC(STABLE_CYC),
    .GAP_CYC   (GAP_CYC),
    .WDOG_CYC  (WDOG_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .ch_hold_req  (ch_hold_req),
    .rst_out      (rst_out),
    .seq_done     (seq_done),
    .lock_lost_cnt(lock_lost_cnt),
    .wdog_timeout (wdog_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_at(input int c);
    exp_t e;
    e.cyc = c; e.r = er; e.d = ed; e.l = el; e.w = ew;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // t = first cycle lock_s is high while in HOLD; queue the first nrel release steps
  task automatic bring_up(input int t, input int nrel);
    logic [3:0] nxt;
    for (int k = 1; k <= nrel; k++) begin
      nxt = (4'hF << k) | ch_hold_req;
      if (nxt != er) begin
        er = nxt;
        expect_at(t + STABLE_CYC + 1 + (k - 1) * GAP_CYC + 1);
      end
    end
    if (nrel == NUM_CH) begin
      ed = 1'b1;
      expect_at(t + STABLE_CYC + 1 + NUM_CH * GAP_CYC + 1);
    end
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  initial begin : monitor
    logic [13:0] prev, cur;
    exp_t e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {rst_out, seq_done, lock_lost_cnt, wdog_timeout};
      if (cur !== prev) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: cyc %0d got rst_out=%h seq_done=%b lock_lost_cnt=%0d wdog=%b, expected no change",
                   cyc, rst_out, seq_done, lock_lost_cnt, wdog_timeout);
        end else begin
          e = sb.pop_front();
          if (((e.cyc >= 0) && (e.cyc != cyc)) || (cur !== {e.r, e.d, e.l, e.w})) begin
            fails++;
            $display("FAIL out_change: cyc %0d got rst_out=%h seq_done=%b lock_lost_cnt=%0d wdog=%b, expected cyc %0d rst_out=%h seq_done=%b lock_lost_cnt=%0d wdog=%b",
                     cyc, rst_out, seq_done, lock_lost_cnt, wdog_timeout, e.cyc, e.r, e.d, e.l, e.w);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stim
    int t, t2, a, b, c, e, r0;

    // reset applied before any clock edge
    expect_at(-1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_no_clk", 32'(rst_out), 32'hF);
    check("async_seq_done_no_clk", 32'(seq_done), 32'h0);
    repeat (2) @(negedge clk);

    // clean bring-up
    rst = 1'b0;
    pll_locked = 1'b1;
    t = cyc + 2;
    bring_up(t, NUM_CH);
    wait_until(t + 40);

    // lock loss in RUN, then relock
    c = cyc;
    pll_locked = 1'b0;
    er = 4'hF; ed = 1'b0; el = 8'd1;
    expect_at(c + 3);
    wait_until(c + 5);
    pll_locked = 1'b1;
    t = cyc + 2;
    bring_up(t, NUM_CH);
    wait_until(t + 40);

    // sw_rst_req from RUN, then again in RELEASE at idx 2
    c = cyc;
    er = 4'hF; ed = 1'b0;
    expect_at(c + 1);
    pulse_sw();
    t = c + 1;
    bring_up(t, 3);
    wait_until(t + 26);
    er = 4'hF;
    expect_at(t + 27);
    pulse_sw();

    // sw_rst_req coincident with lock loss counts once
    t2 = t + 27;
    bring_up(t2, 1);
    wait_until(t2 + 18);
    pll_locked = 1'b0;
    wait_until(t2 + 20);
    er = 4'hF; el = 8'd2;
    expect_at(t2 + 21);
    pulse_sw();

    // one-cycle lock glitch at stable cycle 10
    wait_until(t2 + 24);
    a = cyc;
    pll_locked = 1'b1;
    b = a + 11;
    wait_until(b);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    el = 8'd3;
    expect_at(b + 3);
    t = b + 3;
    bring_up(t, NUM_CH);
    wait_until(t + 40);

    // channel 2 held through bring-up
    c = cyc;
    ch_hold_req = 4'h4;
    er = 4'hF; ed = 1'b0;
    expect_at(c + 1);
    pulse_sw();
    t = c + 1;
    bring_up(t, NUM_CH);
    wait_until(t + 36);
    ch_hold_req = 4'h0;
    er = 4'h0;
    expect_at(cyc + 1);
    wait_until(cyc + 3);

    // asynchronous reset mid-RUN
    e = cyc;
    er = 4'hF; ed = 1'b0; el = 8'd0; ew = 1'b0;
    expect_at(e + 1);
    #1 rst = 1'b1;
    pll_locked = 1'b0;
    #1;
    check("async_rst_out_mid", 32'(rst_out), 32'hF);
    check("async_seq_done_mid", 32'(seq_done), 32'h0);
    check("async_lock_lost_mid", 32'(lock_lost_cnt), 32'h0);
    repeat (3) @(negedge clk);

    // watchdog: wait for lock well past WDOG_CYC
    rst = 1'b0;
    r0 = cyc;
`ifdef RST_SEQ_WDOG_EN
    ew = 1'b1;
    expect_at(r0 + WDOG_CYC);
`endif
    wait_until(r0 + 110);
    pll_locked = 1'b1;
    t = cyc + 2;
    bring_up(t, NUM_CH);
    wait_until(t + 40);
    c = cyc;
    er = 4'hF; ed = 1'b0; ew = 1'b0;
    expect_at(c + 1);
    pulse_sw();
    wait_until(c + 10);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
